// File: rtl/sect163r2_pt_mul_arb.sv
// -----------------------------------------------------------------------------
// sect163r2_pt_mul_arb
//
// Shares one sect163r2 point-multiplication core (d -> d*G) among N_REQ
// requesters. A round-robin arbiter accepts one scalar at a time. The block
// starts the core and captures the affine result. It then returns the result
// with the owning requester ID on a valid/ready response port. A zero scalar
// bypasses the core and is answered as the point at infinity.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   clr               synchronous clear; aborts any in-flight job
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_d             packed scalars, requester i at [i*M +: M]
//   rsp_valid/ready   response handshake
//   rsp_id/inf/x/y    response payload
//   core_clr/start/d  controls and scalar to the point-multiplication core
//   core_done/x/y     core completion pulse and result
//   busy              high whenever a job is in progress
// -----------------------------------------------------------------------------
module sect163r2_pt_mul_arb #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2,
   parameter int M     = 163
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*M-1:0] req_d,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [ID_W-1:0]    rsp_id,
   output logic               rsp_inf,
   output logic [M-1:0]       rsp_x,
   output logic [M-1:0]       rsp_y,
   output logic               core_clr,
   output logic               core_start,
   output logic [M-1:0]       core_d,
   input  logic               core_done,
   input  logic [M-1:0]       core_x,
   input  logic [M-1:0]       core_y,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

   // Pointer starts at the last requester so requester 0 wins first.
   localparam logic [ID_W-1:0] RR_INIT = ID_W'(N_REQ - 1);

   state_t          state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [M-1:0]    core_d_q, core_d_d;
   logic            core_start_q, core_start_d;
   logic [ID_W-1:0] rsp_id_q, rsp_id_d;
   logic            rsp_inf_q, rsp_inf_d;
   logic [M-1:0]    rsp_x_q, rsp_x_d;
   logic [M-1:0]    rsp_y_q, rsp_y_d;

   logic [ID_W-1:0] grant_id;
   logic [M-1:0]    grant_d;
   int              best_dist;
   logic            accept;

   // Round-robin grant: each valid requester's distance past rr_ptr is
   // (i - rr_ptr - 1) mod N_REQ; the smallest distance wins.
   always_comb begin
      // NOTE: every variable gets a default before any branch so the
      // combinational block cannot infer a latch.
      grant_id  = '0;
      grant_d   = '0;
      best_dist = N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
         if (req_valid[i] &&
             (((i + N_REQ - 1 - int'(rr_ptr_q)) % N_REQ) < best_dist)) begin
            best_dist = (i + N_REQ - 1 - int'(rr_ptr_q)) % N_REQ;
            grant_id  = ID_W'(i);
            grant_d   = req_d[i*M +: M];
         end
      end
   end

   assign accept = (state_q == IDLE) && !clr && (|req_valid);

   // rst_n gates the handshake so no request is taken while held in reset.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = rst_n && accept && (grant_id == ID_W'(i));
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      core_d_d = core_d_q;
      rsp_id_d = rsp_id_q;
      rsp_inf_d = rsp_inf_q;
      rsp_x_d  = rsp_x_q;
      rsp_y_d  = rsp_y_q;

      if (clr) begin
         // Clear beats everything, including a same-cycle core_done/rsp_ready.
         state_d   = IDLE;
         rr_ptr_d  = RR_INIT;
         core_d_d  = '0;
         rsp_id_d  = '0;
         rsp_inf_d = 1'b0;
         rsp_x_d   = '0;
         rsp_y_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  core_d_d  = grant_d;
                  rsp_id_d  = grant_id;
                  rr_ptr_d  = grant_id;
                  rsp_inf_d = (grant_d == '0);
                  if (grant_d == '0) begin
                     // 0*G is the point at infinity; the core is skipped.
                     rsp_x_d = '0;
                     rsp_y_d = '0;
                     state_d = RESP;
                  end else begin
                     state_d = START;
                  end
               end
            end
            START: state_d = RUN;
            RUN: begin
               if (core_done) begin
                  rsp_x_d   = core_x;
                  rsp_y_d   = core_y;
                  rsp_inf_d = 1'b0;
                  state_d   = RESP;
               end
            end
            RESP: begin
               if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      // Registered start pulse: high exactly while the FSM sits in START.
      core_start_d = (state_d == START);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of the others.
         state_q      <= IDLE;
         rr_ptr_q     <= RR_INIT;
         core_d_q     <= '0;
         core_start_q <= 1'b0;
         rsp_id_q     <= '0;
         rsp_inf_q    <= 1'b0;
         rsp_x_q      <= '0;
         rsp_y_q      <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         core_d_q     <= core_d_d;
         core_start_q <= core_start_d;
         rsp_id_q     <= rsp_id_d;
         rsp_inf_q    <= rsp_inf_d;
         rsp_x_q      <= rsp_x_d;
         rsp_y_q      <= rsp_y_d;
      end
   end

   assign rsp_valid  = (state_q == RESP);
   assign busy       = (state_q != IDLE);
   assign rsp_id     = rsp_id_q;
   assign rsp_inf    = rsp_inf_q;
   assign rsp_x      = rsp_x_q;
   assign rsp_y      = rsp_y_q;
   assign core_clr   = clr;
   assign core_start = core_start_q;
   assign core_d     = core_d_q;

endmodule

// File: tb/tb_sect163r2_pt_mul_arb.sv
// -----------------------------------------------------------------------------
// tb_sect163r2_pt_mul_arb
//
// Directed bench for the point-multiplication arbiter. The core is a stub
// driven from the main thread: for d==1 it returns the sect163r2 generator G,
// and for other scalars it returns a fixed pattern of d. This is enough to
// prove the result is routed correctly.
// -----------------------------------------------------------------------------
module tb_sect163r2_pt_mul_arb;

   localparam int N_REQ = 4;
   localparam int ID_W  = 2;
   localparam int M     = 163;

   localparam logic [M-1:0] GX = 163'h3f0eba16286a2d57ea0991168d4994637e8343e36;
   localparam logic [M-1:0] GY = 163'h0d51fbc6c71a0094fa2cdd545b11c5c0c797324f1;

   logic               clk;
   logic               rst_n;
   logic               clr;
   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ-1:0]   req_ready;
   logic [N_REQ*M-1:0] req_d;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [ID_W-1:0]    rsp_id;
   logic               rsp_inf;
   logic [M-1:0]       rsp_x;
   logic [M-1:0]       rsp_y;
   logic               core_clr;
   logic               core_start;
   logic [M-1:0]       core_d;
   logic               core_done;
   logic [M-1:0]       core_x;
   logic [M-1:0]       core_y;
   logic               busy;

   int n_checks = 0;
   int n_fail   = 0;

   sect163r2_pt_mul_arb #(.N_REQ(N_REQ), .ID_W(ID_W), .M(M)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_d      (req_d),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_inf    (rsp_inf),
      .rsp_x      (rsp_x),
      .rsp_y      (rsp_y),
      .core_clr   (core_clr),
      .core_start (core_start),
      .core_d     (core_d),
      .core_done  (core_done),
      .core_x     (core_x),
      .core_y     (core_y),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Returns 1 ns after the rising edge; outputs are stable, inputs may change.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [M-1:0] model_x(input logic [M-1:0] d);
      return (d == M'(1)) ? GX : ~d;
   endfunction

   function automatic logic [M-1:0] model_y(input logic [M-1:0] d);
      return (d == M'(1)) ? GY : {d[M-2:0], 1'b1};
   endfunction

   task automatic set_req(input int i, input logic [M-1:0] d);
      req_d[i*M +: M] = d;
      req_valid[i]    = 1'b1;
   endtask

   task automatic reset_dut();
      rst_n     = 1'b0;
      req_valid = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Expects requester id to win this cycle, runs the job with core latency
   // lat, and holds rsp_ready low for hold cycles before consuming.
   task automatic serve(input int id, input logic [M-1:0] d, input int lat, input int hold);
      logic [N_REQ-1:0] onehot;
      logic [M-1:0]     ex, ey;
      onehot     = '0;
      onehot[id] = 1'b1;
      ex = (d == '0) ? '0 : model_x(d);
      ey = (d == '0) ? '0 : model_y(d);
      #1;
      check($sformatf("grant_%0d", id), M'(req_ready), M'(onehot));
      tick();
      req_valid[id] = 1'b0;
      if (d != '0) begin
         check("start_pulse", M'(core_start), M'(1));
         check("core_d_start", core_d, d);
         check("busy_start", M'(busy), M'(1));
         tick();
         check("start_once", M'(core_start), M'(0));
         check("core_d_run", core_d, d);
         for (int k = 1; k < lat; k++) begin
            check("no_early_rsp", M'(rsp_valid), M'(0));
            tick();
         end
         core_done = 1'b1;
         core_x    = model_x(d);
         core_y    = model_y(d);
         tick();
         core_done = 1'b0;
         core_x    = '0;
         core_y    = '0;
      end else begin
         check("zero_no_start", M'(core_start), M'(0));
      end
      check("rsp_valid", M'(rsp_valid), M'(1));
      check("rsp_id", M'(rsp_id), M'(id));
      check("rsp_inf", M'(rsp_inf), M'(d == '0));
      check("rsp_x", rsp_x, ex);
      check("rsp_y", rsp_y, ey);
      for (int h = 0; h < hold; h++) begin
         tick();
         check("hold_valid", M'(rsp_valid), M'(1));
         check("hold_x", rsp_x, ex);
         check("hold_y", rsp_y, ey);
         check("hold_no_ready", M'(req_ready), M'(0));
      end
      rsp_ready = 1'b1;
      #1;
      check("hs_no_ready", M'(req_ready), M'(0));
      tick();
      rsp_ready = 1'b0;
      check("rsp_dropped", M'(rsp_valid), M'(0));
      check("idle", M'(busy), M'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      clr       = 1'b0;
      req_valid = '0;
      req_d     = '0;
      rsp_ready = 1'b0;
      core_done = 1'b0;
      core_x    = '0;
      core_y    = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset values, including req_ready with a request pending in reset.
      req_valid[1] = 1'b1;
      #1;
      check("rst_req_ready", M'(req_ready), M'(0));
      check("rst_rsp_valid", M'(rsp_valid), M'(0));
      check("rst_busy", M'(busy), M'(0));
      check("rst_core_start", M'(core_start), M'(0));
      check("rst_core_d", core_d, '0);
      check("rst_rsp_id", M'(rsp_id), M'(0));
      check("rst_rsp_inf", M'(rsp_inf), M'(0));
      check("rst_rsp_x", rsp_x, '0);
      check("rst_rsp_y", rsp_y, '0);
      clr = 1'b1;
      #1;
      check("core_clr_hi", M'(core_clr), M'(1));
      clr = 1'b0;
      #1;
      check("core_clr_lo", M'(core_clr), M'(0));
      req_valid = '0;
      rst_n     = 1'b1;
      tick();

      // Single request, d=1 gives G.
      set_req(0, M'(1));
      serve(0, M'(1), 3, 0);

      // All four from reset: order 0,1,2,3.
      reset_dut();
      for (int i = 0; i < N_REQ; i++) set_req(i, M'(i + 1));
      serve(0, M'(1), 1, 0);
      serve(1, M'(2), 2, 0);
      serve(2, M'(3), 1, 0);
      serve(3, M'(4), 1, 0);
      // Wrap from rr_ptr=3 and fairness between 1 and 3.
      set_req(1, M'(11));
      set_req(3, M'(13));
      serve(1, M'(11), 1, 0);
      set_req(1, M'(12));
      serve(3, M'(13), 1, 0);
      serve(1, M'(12), 1, 0);
      // Everyone re-requests after grant 1: 2,3,0,1.
      for (int i = 0; i < N_REQ; i++) set_req(i, M'(20 + i));
      serve(2, M'(22), 1, 0);
      serve(3, M'(23), 1, 0);
      serve(0, M'(20), 1, 0);
      serve(1, M'(21), 1, 0);

      // Zero scalar bypasses the core.
      set_req(2, '0);
      serve(2, '0, 1, 0);

      // Back-pressure: response held 20 cycles with req1 pending.
      set_req(0, M'(5));
      set_req(1, M'(6));
      serve(0, M'(5), 2, 20);
      serve(1, M'(6), 1, 0);

      // clr during RUN collides with core_done.
      set_req(1, M'(7));
      #1;
      check("clr_grant", M'(req_ready), M'(4'b0010));
      tick();
      req_valid[1] = 1'b0;
      tick();
      tick();
      set_req(0, M'(8));
      set_req(2, M'(9));
      clr       = 1'b1;
      core_done = 1'b1;
      core_x    = model_x(M'(7));
      core_y    = model_y(M'(7));
      #1;
      check("clr_core_clr", M'(core_clr), M'(1));
      check("clr_no_ready", M'(req_ready), M'(0));
      tick();
      clr       = 1'b0;
      core_done = 1'b0;
      core_x    = '0;
      core_y    = '0;
      check("clr_no_rsp", M'(rsp_valid), M'(0));
      check("clr_idle", M'(busy), M'(0));
      check("clr_rsp_x", rsp_x, '0);
      check("clr_rsp_id", M'(rsp_id), M'(0));
      check("clr_no_start", M'(core_start), M'(0));
      // rr_ptr was reset, so req0 beats req2.
      serve(0, M'(8), 1, 0);
      serve(2, M'(9), 1, 0);

      // rst_n mid-RUN with req1 still asserting.
      set_req(1, M'(1));
      tick();
      check("rr_start", M'(core_start), M'(1));
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("arst_busy", M'(busy), M'(0));
      check("arst_rsp_valid", M'(rsp_valid), M'(0));
      check("arst_core_d", core_d, '0);
      check("arst_core_start", M'(core_start), M'(0));
      check("arst_req_ready", M'(req_ready), M'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      serve(1, M'(1), 2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sect163r2_pt_mul_arb.md
Name: sect163r2_pt_mul_arb

Overview:
Round-robin arbiter and sequencer that shares one sect163r2 point-multiplication core (scalar d in, d*G out) among N_REQ requesters. It accepts one scalar at a time, starts the core, and captures the affine result. It returns the result with the requester ID through a valid/ready response port. Zero scalars bypass the core and return the point at infinity.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, requester ID width, equal to clog2(N_REQ)
M, 163, field/scalar width

Ports:
clk  input  1  system clock
rst_n  input  1  system asynchronous reset, active low
clr  input  1  synchronous clear
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester accept, one-hot or zero
req_d  input  N_REQ*M  packed scalars; requester i uses bits [i*M +: M]
rsp_valid  output  1  result valid
rsp_ready  input  1  result accepted
rsp_id  output  ID_W  requester that owns the result
rsp_inf  output  1  result is the point at infinity (d==0)
rsp_x  output  M  x coordinate of d*G
rsp_y  output  M  y coordinate of d*G
core_clr  output  1  clear to core
core_start  output  1  start pulse to core
core_d  output  M  scalar to core
core_done  input  1  core completion pulse
core_x  input  M  core x result, valid while core_done=1
core_y  input  M  core y result, valid while core_done=1
busy  output  1  state != IDLE

Behaviour:
- One clock domain. rst_n is asynchronous and active low.
- Reset values: all registers 0, state=IDLE, rr_ptr=N_REQ-1, so requester 0 has highest priority first.
- Reset values of outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_inf=0, rsp_x=0, rsp_y=0, core_start=0, core_d=0, busy=0.
- core_clr is combinational and equals clr.
- FSM states: IDLE, START, RUN, RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching from rr_ptr+1 upward modulo N_REQ.
  - req_ready[grant]=1 combinationally when any req_valid is set and clr=0. All other req_ready bits are 0.
  - On transfer (valid & ready): latch d into core_d and the ID into rsp_id, and set rr_ptr=grant.
  - Next state is START if d!=0. If d==0, next state is RESP with rsp_inf=1 and rsp_x=rsp_y=0.
- START:
  - core_start=1 for exactly one cycle, registered output.
  - Next state RUN.
- RUN:
  - Wait for core_done.
  - In the first cycle core_done=1, capture core_x/core_y into rsp_x/rsp_y and set rsp_inf=0.
  - Next state RESP.
  - core_done while not in RUN is ignored.
- RESP:
  - rsp_valid=1, with rsp_id, rsp_inf, rsp_x and rsp_y held stable until rsp_valid & rsp_ready.
  - Next state IDLE.
  - No new request is accepted before the response is consumed.
- core_d is held constant from START through the end of RUN.
- Requesters must hold req_valid and req_d until req_ready. The arbiter never drops an asserted request.
- Latency: transfer at cycle T, core_start at T+1. If core_done occurs at T+1+L, rsp_valid rises at T+2+L. For d==0, rsp_valid rises at T+1.
- Fairness: a continuously requesting requester waits at most N_REQ-1 other grants.
- clr=1 (any state):
  - Next state is IDLE; rsp_valid, core_start and req_ready go to 0.
  - rr_ptr=N_REQ-1, rsp_* fields are cleared, and the in-flight job is discarded.
  - clr has priority over every other event in the same cycle, including simultaneous core_done or rsp_ready.
- rst_n low mid-operation: all state returns to reset values immediately. No response is issued for the aborted job.
- Widths: ID_W must satisfy 2^ID_W >= N_REQ. The modulo wrap from rr_ptr=N_REQ-1 goes to 0.

Test Plan:
- Single request, req0 d=1 -> core_start one cycle after accept; rsp_id=0, rsp_inf=0, rsp_x=3f0eba16286a2d57ea0991168d4994637e8343e36, rsp_y=0d51fbc6c71a0094fa2cdd545b11c5c0c797324f1.
- All four requesters valid from reset with d=1,2,3,4 -> grant order 0,1,2,3; each rsp_id matches; req3 re-asserted after its grant is served only after 0,1,2 if they also re-request.
- req2 d=0 -> no core_start; rsp_valid one cycle after accept; rsp_inf=1, x=y=0, rsp_id=2.
- rsp_ready held low 20 cycles after rsp_valid -> rsp_* stable, req_ready stays 0 for pending req1; accepted only the cycle after rsp_ready=1 handshake.
- clr pulsed during RUN, with core_done arriving in the same cycle -> no rsp_valid, state IDLE, core_clr=1 that cycle, rr_ptr reset so req0 wins next.
- rst_n asserted low mid-RUN then released, with req1 still valid -> outputs at reset values; req1 is re-accepted and completes normally with correct d*G.
